// File: rtl/cpu_multicycle_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer (master) and the
// datapath or test harness (slave).
interface cpu_multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             halt_req;
  logic [1:0]       opcode;
  logic             mem_ready;
  logic             PcWrite;
  logic             IrWrite;
  logic             RegDst;
  logic             ALUSrc;
  logic [1:0]       ALUop;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             RegWrite;
  logic             busy;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  run, halt_req, opcode, mem_ready,
    output PcWrite, IrWrite, RegDst, ALUSrc, ALUop, MemRead, MemWrite,
           MemToReg, RegWrite, busy, halted, err, instr_retired
  );

  modport slave (
    output run, halt_req, opcode, mem_ready,
    input  PcWrite, IrWrite, RegDst, ALUSrc, ALUop, MemRead, MemWrite,
           MemToReg, RegWrite, busy, halted, err, instr_retired
  );
endinterface

// File: rtl/cpu_multicycle_sequencer.sv
// Moore FSM stepping each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Define SEQ_PERF_CNT_EN to build the retired-instruction counter.
module cpu_multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  cpu_multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    OP_R = 2'b00, OP_LW = 2'b01, OP_SW = 2'b10, OP_ADDI = 2'b11
  } op_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       busy;
    logic       halted;
    logic       err;
  } ctl_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_n;
  op_t        op_q, op_n;
  logic [7:0] wait_cnt, wait_n;
  logic       retire;
  ctl_t       ctl_q;

  // Output decode depends only on (state, latched opcode), never on live inputs.
  function automatic ctl_t decode(state_t s, op_t op);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src = (op != OP_R);
        c.alu_op  = (op == OP_R) ? 2'b10 : 2'b00;
      end
      S_MEM: begin
        c.alu_src   = 1'b1;
        c.alu_op    = 2'b00;
        c.mem_read  = (op == OP_LW);
        c.mem_write = (op == OP_SW);
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = (op == OP_R);
        c.mem_to_reg = (op == OP_LW);
        c.alu_src    = (op != OP_R);
        c.alu_op     = (op == OP_R) ? 2'b10 : 2'b00;
      end
      S_HALT:  c.halted = 1'b1;
      S_ERROR: c.err    = 1'b1;
      default: ;
    endcase
    c.busy = (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
             (s == S_MEM)   || (s == S_WB);
    return c;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    op_n    = op_q;
    wait_n  = wait_cnt;
    retire  = 1'b0;
    case (state)
      S_IDLE:   if (bus.run) state_n = S_FETCH;
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        op_n    = op_t'(bus.opcode);
        state_n = S_EXEC;
      end
      S_EXEC:   state_n = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      S_MEM: begin
        // mem_ready wins over a timeout landing on the same cycle.
        if (bus.mem_ready) begin
          wait_n = '0;
          if (op_q == OP_SW) retire  = 1'b1;
          else               state_n = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_n  = '0;
          state_n = S_ERROR;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      S_WB:     retire = 1'b1;
      S_HALT:   if (!bus.halt_req && bus.run) state_n = S_FETCH;
      S_ERROR:  state_n = S_ERROR;
      default:  state_n = S_IDLE;
    endcase
    // halt_req is only honoured at an instruction boundary.
    if (retire) state_n = bus.halt_req ? S_HALT : S_FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_R;
      wait_cnt <= '0;
      ctl_q    <= '0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      wait_cnt <= wait_n;
      ctl_q    <= decode(state_n, op_n);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset)       retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  assign bus.instr_retired = retired_q;
`else
  assign bus.instr_retired = '0;
`endif

  assign bus.PcWrite  = ctl_q.pc_write;
  assign bus.IrWrite  = ctl_q.ir_write;
  assign bus.RegDst   = ctl_q.reg_dst;
  assign bus.ALUSrc   = ctl_q.alu_src;
  assign bus.ALUop    = ctl_q.alu_op;
  assign bus.MemRead  = ctl_q.mem_read;
  assign bus.MemWrite = ctl_q.mem_write;
  assign bus.MemToReg = ctl_q.mem_to_reg;
  assign bus.RegWrite = ctl_q.reg_write;
  assign bus.busy     = ctl_q.busy;
  assign bus.halted   = ctl_q.halted;
  assign bus.err      = ctl_q.err;

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle control vector,
// a negedge monitor pops and compares it against the sequencer outputs.
module tb_cpu_multicycle_sequencer;

  localparam int CNT_W = 16;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PcWrite, IrWrite, RegDst, ALUSrc, ALUop[1:0], MemRead, MemWrite,
  //  MemToReg, RegWrite, busy, halted, err}
  localparam logic [12:0] E_IDLE    = 13'b0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [12:0] E_FETCH   = 13'b1_1_0_0_00_0_0_0_0_1_0_0;
  localparam logic [12:0] E_DEC     = 13'b0_0_0_0_00_0_0_0_0_1_0_0;
  localparam logic [12:0] E_EXEC_R  = 13'b0_0_0_0_10_0_0_0_0_1_0_0;
  localparam logic [12:0] E_EXEC_I  = 13'b0_0_0_1_00_0_0_0_0_1_0_0;
  localparam logic [12:0] E_MEM_LW  = 13'b0_0_0_1_00_1_0_0_0_1_0_0;
  localparam logic [12:0] E_MEM_SW  = 13'b0_0_0_1_00_0_1_0_0_1_0_0;
  localparam logic [12:0] E_WB_R    = 13'b0_0_1_0_10_0_0_0_1_1_0_0;
  localparam logic [12:0] E_WB_LW   = 13'b0_0_0_1_00_0_0_1_1_1_0_0;
  localparam logic [12:0] E_WB_ADDI = 13'b0_0_0_1_00_0_0_0_1_1_0_0;
  localparam logic [12:0] E_HALT    = 13'b0_0_0_0_00_0_0_0_0_0_1_0;
  localparam logic [12:0] E_ERR     = 13'b0_0_0_0_00_0_0_0_0_0_0_1;

  typedef struct {
    string       name;
    logic [12:0] ctl;
    int          cnt;
  } item_t;

  logic  clk;
  logic  reset;
  item_t sb[$];
  int    checks;
  int    failures;

  cpu_multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cpu_multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ec(input int n);
    return PERF ? n : 0;
  endfunction

  // Clock one edge with the currently driven inputs and queue what should show.
  task automatic step(input string nm, input logic [12:0] e, input int cnt);
    item_t it;
    @(posedge clk);
    #1;
    it.name = nm;
    it.ctl  = e;
    it.cnt  = ec(cnt);
    sb.push_back(it);
  endtask

  // Monitor
  initial begin
    item_t       it;
    logic [12:0] obs;
    forever begin
      @(negedge clk);
      obs = {bus.PcWrite, bus.IrWrite, bus.RegDst, bus.ALUSrc, bus.ALUop,
             bus.MemRead, bus.MemWrite, bus.MemToReg, bus.RegWrite,
             bus.busy, bus.halted, bus.err};
      check("mem_rw_exclusive", 32'(bus.MemRead & bus.MemWrite), 32'd0);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check({it.name, "_ctl"}, 32'(obs), 32'(it.ctl));
        check({it.name, "_cnt"}, 32'(bus.instr_retired), 32'(it.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.halt_req  = 1'b0;
    bus.opcode    = 2'b00;
    bus.mem_ready = 1'b1;
    step("rst0", E_IDLE, 0);
    step("rst1", E_IDLE, 0);
    reset = 1'b0;
    step("idle", E_IDLE, 0);

    // R-type with single-cycle run pulse
    bus.run = 1'b1;
    step("r_fetch", E_FETCH, 0);
    bus.run = 1'b0;
    step("r_decode", E_DEC, 0);
    step("r_exec", E_EXEC_R, 0);
    step("r_wb", E_WB_R, 0);
    step("r_next_fetch", E_FETCH, 1);

    // LW with three wait cycles; ready lands on the timeout boundary cycle
    bus.opcode    = 2'b01;
    bus.mem_ready = 1'b0;
    step("lw_decode", E_DEC, 1);
    step("lw_exec", E_EXEC_I, 1);
    step("lw_mem1", E_MEM_LW, 1);
    step("lw_mem2", E_MEM_LW, 1);
    step("lw_mem3", E_MEM_LW, 1);
    step("lw_mem4", E_MEM_LW, 1);
    bus.mem_ready = 1'b1;
    step("lw_wb", E_WB_LW, 1);
    step("lw_next_fetch", E_FETCH, 2);

    // SW completing on the first MEM cycle
    bus.opcode = 2'b10;
    step("sw_decode", E_DEC, 2);
    step("sw_exec", E_EXEC_I, 2);
    step("sw_mem", E_MEM_SW, 2);
    step("sw_next_fetch", E_FETCH, 3);

    // ADDI with halt requested mid-instruction
    bus.opcode = 2'b11;
    step("addi_decode", E_DEC, 3);
    step("addi_exec", E_EXEC_I, 3);
    bus.halt_req = 1'b1;
    step("addi_wb", E_WB_ADDI, 3);
    bus.run = 1'b1;
    step("halt_enter", E_HALT, 4);
    step("halt_hold_run", E_HALT, 4);
    bus.halt_req = 1'b0;
    step("halt_resume", E_FETCH, 4);
    bus.run = 1'b0;

    // LW memory timeout
    bus.opcode    = 2'b01;
    bus.mem_ready = 1'b0;
    step("to_decode", E_DEC, 4);
    step("to_exec", E_EXEC_I, 4);
    step("to_mem1", E_MEM_LW, 4);
    step("to_mem2", E_MEM_LW, 4);
    step("to_mem3", E_MEM_LW, 4);
    step("to_mem4", E_MEM_LW, 4);
    bus.run = 1'b1;
    step("to_error", E_ERR, 4);
    step("to_error_run", E_ERR, 4);
    bus.run = 1'b0;
    reset = 1'b1;
    step("to_reset", E_IDLE, 0);
    reset = 1'b0;

    // Reset during a SW MEM wait
    bus.run = 1'b1;
    step("swr_fetch", E_FETCH, 0);
    bus.run    = 1'b0;
    bus.opcode = 2'b10;
    step("swr_decode", E_DEC, 0);
    step("swr_exec", E_EXEC_I, 0);
    step("swr_mem1", E_MEM_SW, 0);
    step("swr_mem2", E_MEM_SW, 0);
    reset = 1'b1;
    step("swr_reset", E_IDLE, 0);
    reset = 1'b0;
    step("swr_idle", E_IDLE, 0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
